// File: rtl/ndp_result_drain_if.sv
// Valid/ready word stream from the NDP result drain to the memory write path.
// master drives the word; slave consumes it.
interface ndp_result_drain_if #(
   parameter int unsigned OUT_WIDTH = 32
);
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/ndp_result_drain.sv
// Snapshots the NDP core result bus on the rising edge of calc_done_flag and streams it
// out as OUT_WIDTH-bit words. Optional NDP_DRAIN_RELU_EN zeroes negative lanes on output.
module ndp_result_drain #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ARR_WIDTH  = 4,
   parameter int unsigned ARR_HEIGHT = 4,
   parameter int unsigned SYS_WIDTH  = 64,
   parameter int unsigned SYS_HEIGHT = 1,
   parameter int unsigned OUT_WIDTH  = 32,
   localparam int unsigned TOTAL_BITS = ARR_WIDTH * SYS_WIDTH * ARR_HEIGHT * SYS_HEIGHT * WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  calc_done_flag,
   input  logic [TOTAL_BITS-1:0] out_c,
   ndp_result_drain_if.master    drain,
   output logic                  busy,
   output logic                  drain_done
);
   localparam int unsigned NUM_WORDS = TOTAL_BITS / OUT_WIDTH;
   localparam int unsigned LANES     = OUT_WIDTH / WIDTH;
   localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
   localparam int unsigned CNT_W     = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

   state_e                              state_q, state_d;
   logic [CNT_W-1:0]                    word_cnt_q, word_cnt_d;
   logic                                done_q;
   logic                                load;
   logic                                is_last;
   logic                                streaming;
   logic [NUM_WORDS-1:0][OUT_WIDTH-1:0] snap_q;
   logic [LANES-1:0][WIDTH-1:0]         word;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         done_q     <= calc_done_flag;
      end
   end

   // Snapshot needs no reset: out_data is gated to zero outside StStream.
   always_ff @(posedge clk) begin
      if (load) begin
         snap_q <= out_c;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      load       = 1'b0;
      is_last    = (word_cnt_q == LAST_CNT);
      unique case (state_q)
         StIdle: begin
            if (calc_done_flag && !done_q) begin
               load       = 1'b1;
               word_cnt_d = '0;
               state_d    = StStream;
            end
         end
         StStream: begin
            if (drain.out_ready) begin
               if (is_last) begin
                  state_d = StDone;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            if (!calc_done_flag) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      streaming = (state_q == StStream);
      word      = snap_q[word_cnt_q[IDX_W-1:0]];
`ifdef NDP_DRAIN_RELU_EN
      for (int l = 0; l < LANES; l++) begin
         if (word[l][WIDTH-1]) begin
            word[l] = '0;
         end
      end
`endif
      drain.out_valid = streaming;
      drain.out_last  = streaming && is_last;
      drain.out_data  = streaming ? word : '0;
      busy            = streaming;
      drain_done      = (state_q == StDone);
   end
endmodule

// File: tb/tb_ndp_result_drain.sv
// Scoreboard bench for ndp_result_drain: expected words queued at stimulus time,
// popped and compared on every accepted transfer.
module tb_ndp_result_drain;
   localparam int TOTAL_BITS = 16384;
   localparam int NUM_WORDS  = 512;
   localparam int NUM_LANES  = 1024;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  calc_done_flag;
   logic [TOTAL_BITS-1:0] out_c;
   logic                  busy;
   logic                  drain_done;

   int n_vec = 0;
   int n_err = 0;
   logic [32:0] sb[$];

   ndp_result_drain_if #(.OUT_WIDTH(32)) drain_if ();

   ndp_result_drain dut (
      .clk           (clk),
      .reset         (reset),
      .calc_done_flag(calc_done_flag),
      .out_c         (out_c),
      .drain         (drain_if),
      .busy          (busy),
      .drain_done    (drain_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] lane(input int pat, input int i);
      if (pat == 0) return 16'(i);
      return (i % 2 == 1) ? 16'h3C00 : 16'hBC00;
   endfunction

   function automatic logic [31:0] relu(input logic [31:0] w);
      logic [31:0] r;
      r = w;
`ifdef NDP_DRAIN_RELU_EN
      if (w[15]) r[15:0] = 16'h0000;
      if (w[31]) r[31:16] = 16'h0000;
`endif
      return r;
   endfunction

   task automatic load(input int pat);
      for (int i = 0; i < NUM_LANES; i++) out_c[i*16 +: 16] = lane(pat, i);
   endtask

   task automatic push_all(input int pat);
      for (int k = 0; k < NUM_WORDS; k++)
         sb.push_back({(k == NUM_WORDS - 1), relu({lane(pat, 2*k + 1), lane(pat, 2*k)})});
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 32'(drain_if.out_valid), 32'd0);
      check({tag, "_last"}, 32'(drain_if.out_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_data"}, drain_if.out_data, 32'd0);
   endtask

   task automatic check_done(input string tag);
      @(negedge clk);
      check({tag, "_done"}, 32'(drain_done), 32'd1);
      check({tag, "_valid"}, 32'(drain_if.out_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Consumes up to 'take' words; clobber overwrites out_c shortly after capture.
   task automatic drain(input int take, input bit rnd, input bit clobber,
                        output int cycles, output logic [31:0] first);
      int          got;
      bit          stalled;
      logic [31:0] sdata;
      logic        slast;
      logic [32:0] e;
      got = 0; cycles = 0; stalled = 1'b0; first = '0; sdata = '0; slast = 1'b0;
      while (got < take && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         if (clobber && cycles == 2) out_c = '1;
         if (stalled) begin
            check("stall_valid", 32'(drain_if.out_valid), 32'd1);
            check("stall_data", drain_if.out_data, sdata);
            check("stall_last", 32'(drain_if.out_last), 32'(slast));
         end
         drain_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (drain_if.out_valid && drain_if.out_ready) begin
            if (sb.size() == 0) begin
               check("sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               if (got == 0) first = drain_if.out_data;
               check("data", drain_if.out_data, e[31:0]);
               check("last", 32'(drain_if.out_last), 32'(e[32]));
               check("busy", 32'(busy), 32'd1);
            end
            got++;
            stalled = 1'b0;
         end else begin
            stalled = drain_if.out_valid;
            sdata   = drain_if.out_data;
            slast   = drain_if.out_last;
         end
      end
      if (got < take) check("drain_timeout", 32'(got), 32'(take));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      logic [31:0] w0;
      reset = 1'b1; calc_done_flag = 1'b0; drain_if.out_ready = 1'b0; out_c = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst");
      check("rst_done", 32'(drain_done), 32'd0);

      // Incrementing lanes, back-to-back transfers.
      load(0); push_all(0);
      drain_if.out_ready = 1'b1;
      calc_done_flag = 1'b1;
      drain(NUM_WORDS, 1'b0, 1'b0, cyc, w0);
      check("burst_cycles", 32'(cyc), 32'(NUM_WORDS));
      check("burst_w0", w0, 32'h0001_0000);
      check_done("t2");
      // Held level must not retrigger; ready held high while idle does nothing.
      repeat (5) @(negedge clk);
      check("hold_valid", 32'(drain_if.out_valid), 32'd0);
      check("hold_done", 32'(drain_done), 32'd1);
      calc_done_flag = 1'b0;
      @(negedge clk);
      check("done_clear", 32'(drain_done), 32'd0);
      repeat (3) @(negedge clk);
      check_idle_outputs("idle_ready");

      // Random backpressure.
      push_all(0);
      calc_done_flag = 1'b1;
      drain(NUM_WORDS, 1'b1, 1'b0, cyc, w0);
      check_done("t3");
      calc_done_flag = 1'b0;
      @(negedge clk);

      // Overwrite out_c after capture.
      push_all(0);
      calc_done_flag = 1'b1;
      drain(NUM_WORDS, 1'b0, 1'b1, cyc, w0);
      check_done("t4");
      calc_done_flag = 1'b0;
      @(negedge clk);

      // Reset mid-stream, then restart from word 0.
      load(0); push_all(0);
      calc_done_flag = 1'b1;
      drain(100, 1'b0, 1'b0, cyc, w0);
      reset = 1'b1; calc_done_flag = 1'b0;
      @(negedge clk);
      check_idle_outputs("mid_rst");
      reset = 1'b0;
      sb.delete();
      push_all(0);
      @(negedge clk);
      check_idle_outputs("post_rst");
      calc_done_flag = 1'b1;
      drain(NUM_WORDS, 1'b1, 1'b0, cyc, w0);
      check("restart_w0", w0, 32'h0001_0000);
      check_done("t5");
      calc_done_flag = 1'b0;
      @(negedge clk);

      // Signed lanes: negative lanes zeroed only when ReLU is built in.
      load(1); push_all(1);
      calc_done_flag = 1'b1;
      drain(NUM_WORDS, 1'b0, 1'b0, cyc, w0);
`ifdef NDP_DRAIN_RELU_EN
      check("sign_w0", w0, 32'h3C00_0000);
`else
      check("sign_w0", w0, 32'h3C00_BC00);
`endif
      check_done("t6");
      check("sb_left", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
